// File: rtl/pc_unit_pkg.sv
// Shared encodings for the PC stage: next-PC selects, FSM states and the IM window base.
package pc_unit_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
    localparam int unsigned DEFAULT_IM_WORDS = 1024;

    // npc_sel encodings
    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;

    typedef enum logic {
        StRun   = 1'b0,
        StFault = 1'b1
    } state_e;

endpackage

// File: rtl/pc_unit_if.sv
// Core-side bundle of the PC stage: next-PC controls in, fetch address and status out.
interface pc_unit_if;

    logic        stall;
    logic [1:0]  npc_sel;
    logic        br_taken;
    logic [15:0] imm16;
    logic [25:0] target26;
    logic [31:0] rs_data;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_cnt;

    // Controller side
    modport master (
        output stall, npc_sel, br_taken, imm16, target26, rs_data,
        input  pc, pc_plus4, fault, fault_pc, fetch_cnt
    );

    // PC stage side
    modport slave (
        input  stall, npc_sel, br_taken, imm16, target26, rs_data,
        output pc, pc_plus4, fault, fault_pc, fetch_cnt
    );

endinterface

// File: rtl/pc_unit_npc_calc.sv
// Combinational next-PC candidate generator with IM-window legality check.
module pc_unit_npc_calc
    import pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned IM_WORDS = DEFAULT_IM_WORDS
) (
    input  logic [31:0] pc,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] target26,
    input  logic [31:0] rs_data,
    output logic [31:0] pc_plus4,
    output logic [31:0] candidate,
    output logic        illegal
);

    localparam logic [31:0] LAST_PC = RESET_PC + 32'(IM_WORDS * 4) - 32'd4;

    logic [31:0] br_off;

    // Select the next-PC candidate; all sums wrap modulo 2^32
    always_comb begin
        pc_plus4  = pc + 32'd4;
        br_off    = {{14{imm16[15]}}, imm16, 2'b00};
        candidate = pc_plus4;
        unique case (npc_sel)
            NPC_SEQ: candidate = pc_plus4;
            NPC_BR:  candidate = br_taken ? (pc_plus4 + br_off) : pc_plus4;
            NPC_J:   candidate = {pc_plus4[31:28], target26, 2'b00};
            NPC_JR:  candidate = rs_data;
        endcase
    end

    // Misaligned or outside the IM window; a wrapped pc+4 lands below RESET_PC
    always_comb begin
        illegal = (candidate[1:0] != 2'b00) || (candidate < RESET_PC) || (candidate > LAST_PC);
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: PC register, RUN/FAULT controller and saturating fetch counter.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned IM_WORDS = DEFAULT_IM_WORDS
) (
    input  logic       clk,
    input  logic       rst_n,
    pc_unit_if.slave   bus
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fault_pc_q, fault_pc_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] pc_plus4;
    logic [31:0] candidate;
    logic        illegal;

    pc_unit_npc_calc #(
        .RESET_PC (RESET_PC),
        .IM_WORDS (IM_WORDS)
    ) u_npc_calc (
        .pc        (pc_q),
        .npc_sel   (bus.npc_sel),
        .br_taken  (bus.br_taken),
        .imm16     (bus.imm16),
        .target26  (bus.target26),
        .rs_data   (bus.rs_data),
        .pc_plus4  (pc_plus4),
        .candidate (candidate),
        .illegal   (illegal)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: stall suppresses the legality check; FAULT only leaves via reset
    always_comb begin
        state_d = state_q;
        if (state_q == StRun && !bus.stall && illegal) begin
            state_d = StFault;
        end
    end

    // FSM and datapath outputs
    always_comb begin
        bus.pc        = pc_q;
        bus.pc_plus4  = pc_plus4;
        bus.fault     = (state_q == StFault);
        bus.fault_pc  = fault_pc_q;
        bus.fetch_cnt = fetch_cnt_q;
    end

    // Datapath next state: step PC on an accepted fetch, capture the rejected address
    always_comb begin
        pc_d        = pc_q;
        fault_pc_d  = fault_pc_q;
        fetch_cnt_d = fetch_cnt_q;
        if (state_q == StRun && !bus.stall) begin
            if (illegal) begin
                fault_pc_d = candidate;
            end else begin
                pc_d = candidate;
                if (fetch_cnt_q != 32'hFFFF_FFFF) begin
                    fetch_cnt_d = fetch_cnt_q + 32'd1;
                end
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            fault_pc_q  <= 32'h0;
            fetch_cnt_q <= 32'h0;
        end else begin
            pc_q        <= pc_d;
            fault_pc_q  <= fault_pc_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios then randomized traffic vs. a reference model.
module tb_pc_unit;
    import pc_unit_pkg::*;

    localparam logic [31:0]     RPC  = 32'h0000_3000;
    localparam longint unsigned LAST = 64'h3000 + 4 * 1024 - 4;
    localparam longint unsigned MASK = 64'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_unit_if bus();

    pc_unit #(
        .RESET_PC (RPC),
        .IM_WORDS (1024)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference state
    longint unsigned m_pc, m_fault_pc, m_cnt;
    bit              m_fault;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned model_cand(input logic [1:0] sel, input bit br,
                                                   input logic [15:0] imm, input logic [25:0] tgt,
                                                   input logic [31:0] rs);
        longint unsigned nxt = (m_pc + 4) & MASK;
        longint          s;
        case (sel)
            2'b00: return nxt;
            2'b01: begin
                s = longint'(nxt) + 4 * longint'($signed(imm));
                return br ? (longint'(s) & MASK) : nxt;
            end
            2'b10: return (nxt / 64'h1000_0000) * 64'h1000_0000 + longint'(tgt) * 4;
            default: return longint'(rs);
        endcase
    endfunction

    function automatic bit model_illegal(input longint unsigned c);
        return (c % 4 != 0) || (c < longint'(RPC)) || (c > LAST);
    endfunction

    task automatic model_reset();
        m_pc       = RPC;
        m_fault    = 1'b0;
        m_fault_pc = 0;
        m_cnt      = 0;
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".pc"}, bus.pc, m_pc[31:0]);
        check_eq({tag, ".pc4"}, bus.pc_plus4, 32'((m_pc + 4) & MASK));
        check_eq({tag, ".fault"}, {31'b0, bus.fault}, {31'b0, m_fault});
        check_eq({tag, ".fpc"}, bus.fault_pc, m_fault_pc[31:0]);
        check_eq({tag, ".cnt"}, bus.fetch_cnt, m_cnt[31:0]);
    endtask

    // Called 1 time unit after a rising edge; drives, predicts, then checks after the next edge
    task automatic cycle(input string tag, input bit st, input logic [1:0] sel, input bit br,
                         input logic [15:0] imm, input logic [25:0] tgt, input logic [31:0] rs);
        longint unsigned c;
        bus.stall    = st;
        bus.npc_sel  = sel;
        bus.br_taken = br;
        bus.imm16    = imm;
        bus.target26 = tgt;
        bus.rs_data  = rs;
        c = model_cand(sel, br, imm, tgt, rs);
        if (!m_fault && !st) begin
            if (model_illegal(c)) begin
                m_fault    = 1'b1;
                m_fault_pc = c;
            end else begin
                m_pc = c;
                if (m_cnt != MASK) m_cnt++;
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse in mid-cycle; outputs must clear before any clock edge
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all(tag);
        rst_n = 1'b1;
    endtask

    int fault_cycles;

    initial begin
        bus.stall    = 1'b0;
        bus.npc_sel  = NPC_SEQ;
        bus.br_taken = 1'b0;
        bus.imm16    = '0;
        bus.target26 = '0;
        bus.rs_data  = '0;
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;

        // Sequential fetch
        for (int i = 0; i < 5; i++) cycle("seq", 0, NPC_SEQ, 0, '0, '0, '0);
        check_eq("seq5.pc", bus.pc, 32'h3014);
        check_eq("seq5.cnt", bus.fetch_cnt, 32'd5);

        // Branch taken / not taken from 3010
        cycle("jr3010", 0, NPC_JR, 0, '0, '0, 32'h3010);
        cycle("br_t", 0, NPC_BR, 1, 16'hFFFC, '0, '0);
        check_eq("br_t.pc", bus.pc, 32'h3004);
        cycle("jr3010b", 0, NPC_JR, 0, '0, '0, 32'h3010);
        cycle("br_nt", 0, NPC_BR, 0, 16'hFFFC, '0, '0);
        check_eq("br_nt.pc", bus.pc, 32'h3014);

        // Jump and jump-register
        cycle("j", 0, NPC_J, 0, '0, 26'h0000C20, '0);
        check_eq("j.pc", bus.pc, 32'h3080);
        cycle("jr", 0, NPC_JR, 0, '0, '0, 32'h3100);
        check_eq("jr.pc", bus.pc, 32'h3100);

        // Misaligned jr faults and freezes
        cycle("jrmis", 0, NPC_JR, 0, '0, '0, 32'h3102);
        check_eq("jrmis.fault", {31'b0, bus.fault}, 32'd1);
        check_eq("jrmis.fpc", bus.fault_pc, 32'h3102);
        check_eq("jrmis.pc", bus.pc, 32'h3100);
        for (int i = 0; i < 10; i++) begin
            cycle("frozen", 1'($urandom), 2'($urandom), 1'($urandom), 16'($urandom),
                  26'($urandom), RPC);
        end
        check_eq("frozen.pc", bus.pc, 32'h3100);

        // Sequential past the last word
        do_reset("rst4");
        cycle("jrlast", 0, NPC_JR, 0, '0, '0, 32'h3FFC);
        cycle("seqend", 0, NPC_SEQ, 0, '0, '0, '0);
        check_eq("seqend.fpc", bus.fault_pc, 32'h4000);
        check_eq("seqend.pc", bus.pc, 32'h3FFC);

        // Stall masks an illegal jr
        do_reset("rst5");
        cycle("seq5b", 0, NPC_SEQ, 0, '0, '0, '0);
        for (int i = 0; i < 3; i++) cycle("stall", 1, NPC_JR, 0, '0, '0, 32'h0);
        check_eq("stall.fault", {31'b0, bus.fault}, 32'd0);
        check_eq("stall.cnt", bus.fetch_cnt, 32'd1);
        cycle("unstall", 0, NPC_SEQ, 0, '0, '0, '0);
        check_eq("unstall.pc", bus.pc, 32'h3008);

        // Async reset while in FAULT
        cycle("jr0", 0, NPC_JR, 0, '0, '0, 32'h0);
        check_eq("jr0.fault", {31'b0, bus.fault}, 32'd1);
        do_reset("rst6");
        check_eq("rst6.pc", bus.pc, 32'h3000);
        check_eq("rst6.fault", {31'b0, bus.fault}, 32'd0);
        check_eq("rst6.cnt", bus.fetch_cnt, 32'd0);

        // Randomized traffic
        fault_cycles = 0;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rs;
            int unsigned r;
            if (m_fault) begin
                fault_cycles++;
                if (fault_cycles > 3) begin
                    do_reset("rrst");
                    fault_cycles = 0;
                end
            end
            r = $urandom_range(0, 9);
            if (r < 7)       rs = RPC + 4 * $urandom_range(0, 1023);
            else if (r == 7) rs = RPC + 4 * $urandom_range(0, 1023) + $urandom_range(1, 3);
            else if (r == 8) rs = 32'(LAST + 4);
            else             rs = $urandom;
            cycle("rnd", ($urandom_range(0, 3) == 0), 2'($urandom), 1'($urandom),
                  16'($urandom_range(0, 128)) - 16'd64,
                  26'(32'h0C00 + $urandom_range(0, 1030)), rs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
